// File: rtl/jt12_pgx.sv
// Time-multiplexed FM phase generator: one accumulator shared by NUM_CH*OPS slots,
// with phase stop/reset, direct increment and a slot-tagged, delayed output.
module jt12_pgx #(
  parameter  int NUM_CH  = 6,
  parameter  int OPS     = 4,
  parameter  int PHW     = 20,
  parameter  int OUTW    = 10,
  parameter  int OUT_DLY = 6,
  localparam int NS      = NUM_CH*OPS,
  localparam int SW      = $clog2(NS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  output logic [SW-1:0]     slot_I,
  input  logic [10:0]       fnum_I,
  input  logic [2:0]        block_I,
  input  logic signed [7:0] pm_I,
  input  logic signed [5:0] dt_I,
  input  logic [3:0]        mul_I,
  input  logic              pg_rst_I,
  input  logic              pg_stop_I,
  input  logic              direct_I,
  input  logic [16:0]       dinc_I,
  output logic [4:0]        keycode_II,
  output logic [OUTW-1:0]   phase_out,
  output logic [SW-1:0]     slot_out,
  output logic              sync
);

  typedef struct packed {
    logic [16:0]   inc;
    logic [3:0]    mul;
    logic          prst;
    logic          pstop;
    logic [SW-1:0] slot;
  } st2_t;

  logic [SW-1:0]                  slot_cnt;
  st2_t                           st2;
  logic [NS-1:0][PHW-1:0]         ph_sr;
  logic [OUT_DLY+1:0][OUTW-1:0]   ph_dly;
  logic [OUT_DLY+1:0][SW-1:0]     sl_dly;

  logic signed [12:0] fm_raw;
  logic [10:0]        fm;
  logic [16:0]        inc_I;
  logic [4:0]         kc_I;
  logic [PHW-1:0]     step, ph_old, ph_new;

  // Stage I: saturated fnum+pm, octave shift, detune, keycode
  always_comb begin
    fm_raw = $signed({2'b00, fnum_I}) + $signed({{5{pm_I[7]}}, pm_I});
    fm     = fm_raw[10:0];
    if (fm_raw[12])      fm = '0;
    else if (fm_raw[11]) fm = 11'h7ff;
    inc_I = 17'((({7'd0, fm} << block_I) >> 1)) + {{11{dt_I[5]}}, dt_I};
    if (direct_I) inc_I = dinc_I;
    kc_I = {block_I, fnum_I[10],
            (fnum_I[10] & (|fnum_I[9:7])) | (~fnum_I[10] & (&fnum_I[9:7]))};
  end

  // Stage II: multiply and accumulate against the slot's entry from the previous frame
  always_comb begin
    ph_old = ph_sr[NS-1];
    if (st2.mul == 4'd0) step = PHW'(st2.inc >> 1);
    else                 step = PHW'(21'(st2.inc) * 21'(st2.mul));
    if (st2.prst)       ph_new = '0;
    else if (st2.pstop) ph_new = ph_old;
    else                ph_new = ph_old + step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      st2        <= '0;
      keycode_II <= '0;
      ph_sr      <= '0;
      ph_dly     <= '0;
      sl_dly     <= '0;
    end else if (clk_en) begin
      slot_cnt   <= (slot_cnt == SW'(NS-1)) ? '0 : slot_cnt + 1'b1;
      st2        <= '{inc: inc_I, mul: mul_I, prst: pg_rst_I, pstop: pg_stop_I, slot: slot_cnt};
      keycode_II <= kc_I;
      // NS-deep shift: the tail always holds the entry written NS updates ago
      ph_sr      <= {ph_sr[NS-2:0], ph_new};
      ph_dly     <= {ph_dly[OUT_DLY:0], ph_new[PHW-1 -: OUTW]};
      sl_dly     <= {sl_dly[OUT_DLY:0], st2.slot};
    end
  end

  assign slot_I    = slot_cnt;
  assign phase_out = ph_dly[OUT_DLY+1];
  assign slot_out  = sl_dly[OUT_DLY+1];
  assign sync      = (slot_out == '0);

endmodule

// File: tb/tb_jt12_pgx.sv
// Randomized bench for jt12_pgx against a per-slot phase model with an output latency queue.
module tb_jt12_pgx;
  localparam int NS = 24, SW = 5, PHW = 20, OUTW = 10, LAT = 8;
  localparam int PMASK = (1 << PHW) - 1;

  logic              clk = 1'b0;
  logic              rst, clk_en;
  logic [SW-1:0]     slot_I;
  logic [10:0]       fnum_I;
  logic [2:0]        block_I;
  logic signed [7:0] pm_I;
  logic signed [5:0] dt_I;
  logic [3:0]        mul_I;
  logic              pg_rst_I, pg_stop_I, direct_I;
  logic [16:0]       dinc_I;
  logic [4:0]        keycode_II;
  logic [OUTW-1:0]   phase_out;
  logic [SW-1:0]     slot_out;
  logic              sync;

  jt12_pgx dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .slot_I(slot_I),
    .fnum_I(fnum_I), .block_I(block_I), .pm_I(pm_I), .dt_I(dt_I), .mul_I(mul_I),
    .pg_rst_I(pg_rst_I), .pg_stop_I(pg_stop_I), .direct_I(direct_I), .dinc_I(dinc_I),
    .keycode_II(keycode_II), .phase_out(phase_out), .slot_out(slot_out), .sync(sync)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // per-slot stimulus configuration
  int c_fnum[NS], c_block[NS], c_pm[NS], c_dt[NS], c_mul[NS], c_dinc[NS];
  bit c_prst[NS], c_pstop[NS], c_dir[NS];
  bit rnd;
  int cur_fnum, cur_block, cur_pm, cur_dt, cur_mul, cur_dinc;
  bit cur_prst, cur_pstop, cur_dir;

  // reference model
  typedef struct { int ph; int sl; } ent_t;
  ent_t q[$];
  int   ph[NS];
  int   m_slot, e_ph, e_sl, e_kc;

  task automatic m_reset();
    for (int i = 0; i < NS; i++) ph[i] = 0;
    m_slot = 0; e_ph = 0; e_sl = 0; e_kc = 0;
    q.delete();
    for (int i = 0; i < LAT; i++) q.push_back('{0, 0});
  endtask

  task automatic m_edge();
    int fm, inc, stp, hi3, b10, kc;
    ent_t e;
    fm = cur_fnum + cur_pm;
    if (fm < 0) fm = 0;
    if (fm > 2047) fm = 2047;
    inc = (((fm << cur_block) >> 1) + cur_dt) & 32'h1ffff;
    if (cur_dir) inc = cur_dinc;
    stp = (cur_mul == 0) ? (inc >> 1) : ((inc * cur_mul) & PMASK);
    if (cur_prst)        ph[m_slot] = 0;
    else if (!cur_pstop) ph[m_slot] = (ph[m_slot] + stp) & PMASK;
    hi3 = (cur_fnum >> 7) & 7;
    b10 = (cur_fnum >> 10) & 1;
    kc  = cur_block * 4 + b10 * 2 + (b10 ? int'(hi3 != 0) : int'(hi3 == 7));
    e.ph = ph[m_slot] >> (PHW - OUTW);
    e.sl = m_slot;
    q.push_back(e);
    e = q.pop_front();
    e_ph = e.ph; e_sl = e.sl; e_kc = kc;
    m_slot = (m_slot + 1) % NS;
  endtask

  task automatic cfg_all(input bit stop);
    for (int i = 0; i < NS; i++) begin
      c_fnum[i] = 0; c_block[i] = 0; c_pm[i] = 0; c_dt[i] = 0; c_mul[i] = 1;
      c_dinc[i] = 0; c_prst[i] = 0; c_pstop[i] = stop; c_dir[i] = 0;
    end
  endtask

  task automatic cyc(input bit en, input bit r);
    @(negedge clk);
    rst = r; clk_en = en;
    if (rnd) begin
      cur_fnum  = int'($urandom_range(0, 2047));
      cur_block = int'($urandom_range(0, 7));
      cur_pm    = int'($urandom_range(0, 255)) - 128;
      cur_dt    = int'($urandom_range(0, 63)) - 32;
      cur_mul   = int'($urandom_range(0, 15));
      cur_dinc  = int'($urandom_range(0, 131071));
      cur_prst  = ($urandom_range(0, 15) == 0);
      cur_pstop = ($urandom_range(0, 7) == 0);
      cur_dir   = ($urandom_range(0, 3) == 0);
    end else begin
      cur_fnum = c_fnum[m_slot]; cur_block = c_block[m_slot]; cur_pm = c_pm[m_slot];
      cur_dt = c_dt[m_slot]; cur_mul = c_mul[m_slot]; cur_dinc = c_dinc[m_slot];
      cur_prst = c_prst[m_slot]; cur_pstop = c_pstop[m_slot]; cur_dir = c_dir[m_slot];
    end
    fnum_I = 11'(cur_fnum); block_I = 3'(cur_block); pm_I = 8'(cur_pm);
    dt_I = 6'(cur_dt); mul_I = 4'(cur_mul); dinc_I = 17'(cur_dinc);
    pg_rst_I = cur_prst; pg_stop_I = cur_pstop; direct_I = cur_dir;
    @(posedge clk); #1;
    if (r)       m_reset();
    else if (en) m_edge();
    chk("slot_I", int'(slot_I), m_slot);
    chk("phase_out", int'(phase_out), e_ph);
    chk("slot_out", int'(slot_out), e_sl);
    chk("sync", int'(sync), int'(e_sl == 0));
    chk("keycode_II", int'(keycode_II), e_kc);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; rnd = 1'b0;
    fnum_I = '0; block_I = '0; pm_I = '0; dt_I = '0; mul_I = '0;
    pg_rst_I = 1'b0; pg_stop_I = 1'b0; direct_I = 1'b0; dinc_I = '0;
    cfg_all(1'b1);
    m_reset();

    // reset held 3 cycles, then the slot counter runs and wraps
    repeat (3) cyc(1'b1, 1'b1);
    chk("rst_phase", int'(phase_out), 0);
    chk("rst_slot_out", int'(slot_out), 0);
    chk("rst_sync", int'(sync), 1);
    chk("rst_keycode", int'(keycode_II), 0);
    repeat (NS + 2) cyc(1'b1, 1'b0);

    // slot 0 alone accumulating 8192 per frame, across a full 128-frame wrap
    c_fnum[0] = 1024; c_block[0] = 4; c_mul[0] = 1; c_pstop[0] = 1'b0;
    repeat (130 * NS) cyc(1'b1, 1'b0);

    // mul=0 halves, mul=3 with +6 detune
    c_fnum[1] = 1024; c_block[1] = 4; c_mul[1] = 0; c_pstop[1] = 1'b0;
    c_fnum[2] = 1024; c_block[2] = 4; c_mul[2] = 3; c_dt[2] = 6; c_pstop[2] = 1'b0;
    repeat (10 * NS) cyc(1'b1, 1'b0);

    // saturation, direct increment ignoring pm/dt, keycode pattern
    c_fnum[3] = 2040; c_pm[3] = 20; c_block[3] = 7; c_pstop[3] = 1'b0;
    c_dir[4] = 1'b1; c_dinc[4] = 17'h1ffff; c_pm[4] = -128; c_dt[4] = -32; c_pstop[4] = 1'b0;
    c_fnum[5] = 11'h380; c_block[5] = 5; c_mul[5] = 2; c_pstop[5] = 1'b0;
    repeat (6 * NS) cyc(1'b1, 1'b0);

    // stop freezes slot 0 only, then reset wins over stop, then release
    repeat (5 * NS) cyc(1'b1, 1'b0);
    c_pstop[0] = 1'b1;
    repeat (3 * NS) cyc(1'b1, 1'b0);
    c_prst[0] = 1'b1;
    repeat (NS) cyc(1'b1, 1'b0);
    c_prst[0] = 1'b0; c_pstop[0] = 1'b0;
    repeat (3 * NS) cyc(1'b1, 1'b0);

    // enable gated 1-of-3, then randomly
    for (int i = 0; i < 12 * NS; i++) cyc(i % 3 == 0, 1'b0);
    for (int i = 0; i < 300; i++) cyc($urandom_range(0, 1) == 1, 1'b0);

    // mid-frame reset at slot 13, asserted while clk_en is low
    for (int i = 0; i < 2 * NS && m_slot != 13; i++) cyc(1'b1, 1'b0);
    chk("pre_rst_slot", int'(slot_I), 13);
    cyc(1'b0, 1'b1);
    repeat (4 * NS) cyc(1'b1, 1'b0);

    // fully random operands including sparse pg_rst/pg_stop/direct
    rnd = 1'b1;
    for (int i = 0; i < 1500; i++) cyc($urandom_range(0, 7) != 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jt12_pgx.md
# jt12_pgx

Parametrised phase generator for the FM operator pipeline. It time-multiplexes one phase accumulator over `NUM_CH*OPS` operator slots and owns the slot counter. It implements the previously unimplemented phase stop, adds a direct-increment mode, and labels its output with a slot index and a frame sync. It sits between the channel/operator register file, which supplies slot inputs indexed by `slot_I`, and the operator/envelope stage, which consumes `phase_out`.

## Interface
Parameters:
- `NUM_CH`, 6: channels.
- `OPS`, 4: operators per channel. `NS = NUM_CH*OPS` slots.
- `PHW`, 20: phase accumulator width, ≥17.
- `OUTW`, 10: output phase width. Output is phase[PHW-1:PHW-OUTW].
- `OUT_DLY`, 6: extra pipeline stages on the output, ≥0.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `clk_en`  in  1: global enable. All state holds when low.
- `slot_I`  out  clog2(NS): slot whose inputs must be presented this cycle.
- `fnum_I`  in  11: frequency number.
- `block_I`  in  3: octave.
- `pm_I`  in  8 signed: LFO fnum offset.
- `dt_I`  in  6 signed: detune offset, computed upstream.
- `mul_I`  in  4: multiplier.
- `pg_rst_I`  in  1: zero this slot's phase.
- `pg_stop_I`  in  1: freeze this slot's phase.
- `direct_I`  in  1: use `dinc_I` as the increment.
- `dinc_I`  in  17: direct increment.
- `keycode_II`  out  5: keycode of the slot sampled on the previous enabled cycle.
- `phase_out`  out  OUTW: phase for `slot_out`.
- `slot_out`  out  clog2(NS): slot tag for `phase_out`.
- `sync`  out  1: high when `slot_out`==0.

## Operation
Slot counter:
- `slot_I` increments once per enabled cycle and wraps from NS-1 to 0.

Stage I (combinational; result registered into stage II):
- fm = fnum_I + pm_I, saturated to 0..2047.
- base = (fm << block_I) >> 1, 17 bits.
- inc = base + dt_I (sign-extended), taken modulo 2^17.
- If direct_I=1: inc = dinc_I, and detune and pm are ignored.
- keycode = {block_I, fnum_I[10], (fnum_I[10] & (fnum_I[9]|fnum_I[8]|fnum_I[7])) | (~fnum_I[10] & fnum_I[9] & fnum_I[8] & fnum_I[7])}. This uses the unmodified fnum_I.
- Registered alongside: mul_I, pg_rst_I, pg_stop_I, slot index.

Stage II:
- step = inc>>1 when mul=0; otherwise inc*mul. Zero-extend or truncate to PHW bits.
- Priority for the slot's new phase:
  - pg_rst: new phase = 0.
  - else pg_stop: new phase = old phase.
  - else: new phase = old phase + step, modulo 2^PHW.
- Old phase comes from an NS-deep PHW-bit circular store. A shift register or RAM plus pointer are both acceptable. The entry for slot s must be the one written on that slot's previous visit.

Output:
- The new phase's top OUTW bits and the slot tag pass through OUT_DLY registers, then drive `phase_out`/`slot_out`/`sync`.

Reset:
- All phase entries = 0.
- `slot_I` = 0.
- Pipeline registers = 0, so `keycode_II`=0, `phase_out`=0, `slot_out`=0, `sync`=1.
- Reset asserted mid-frame restarts at slot 0 on the first enabled cycle after release. No partial state survives.
- `rst` takes effect regardless of `clk_en`.

## Timing
- Inputs for slot s are sampled on the enabled edge that ends the cycle where `slot_I`=s.
- The phase store is written one enabled edge later.
- `phase_out`/`slot_out` for that update appear `2+OUT_DLY` enabled edges after the sampling edge. That is 8 with the defaults.
- `keycode_II` is valid 1 edge after sampling.
- One update per slot per frame of NS enabled cycles. No stalls and no backpressure.
- With `clk_en` low: counter, store and pipeline hold; outputs are stable.
- pg_rst and pg_stop asserted together: reset wins.
- A slot never updated keeps phase 0 until stepped.

## Test plan
- Reset: hold `rst` 3 cycles with `clk_en`=1. Require all outputs 0, `sync`=1, then `slot_I` counts 0..23 and wraps to 0.
- Basic accumulation: slot 0 with fnum=1024, block=4, pm=0, dt=0, mul=1; other slots stopped. Require the slot-0 `phase_out` sequence 8, 16, 24… (step 8192), tagged `slot_out`=0 with `sync`=1. Wraps to 0 after 128 frames.
- Mul and detune: mul=0 gives step 4096 (output +4 per frame). mul=3 with dt=+6 gives step 3*8198=24594.
- Saturation, direct mode, keycode: fnum=2040 with pm=+20 gives fm=2047, with no wrap to a low value. direct_I=1 with dinc=0x1FFFF and mul=1 gives step 131071. fnum=0x380, block=5 gives keycode_II=0b10101.
- Stop and reset priority: after 5 frames, pg_stop=1 freezes the output value. Then pg_rst=1 together with pg_stop=1 gives phase 0. The stop's hold applies only to the stopped slot; other slots keep advancing.
- Enable gating and mid-frame reset: toggle `clk_en` 1-of-3 and require outputs identical to the ungated run, decimated. Assert `rst` at slot 13 and require restart from slot 0 with all phases 0.
